// File: rtl/register_ctrl_pkg.sv
// Ctrl codes shared between the register, its serial loader and benches,
// plus the loader state encoding.
package register_ctrl_pkg;

  localparam logic [2:0] CTRL_NONE                = 3'd0;
  localparam logic [2:0] CTRL_CLR                 = 3'd1;
  localparam logic [2:0] CTRL_PARALLEL_LOAD       = 3'd2;
  localparam logic [2:0] CTRL_SERIAL_MSB_LOAD     = 3'd3;
  localparam logic [2:0] CTRL_SERIAL_LSB_LOAD     = 3'd4;
  localparam logic [2:0] CTRL_SHIFT_LOGICAL_LEFT  = 3'd5;
  localparam logic [2:0] CTRL_SHIFT_LOGICAL_RIGHT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RECEIVE = 3'd2,
    S_PARITY  = 3'd3,
    S_DONE    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/loader_bit_counter.sv
// Counts accepted data bits; terminal flags the WIDTH-th bit (count == WIDTH-1).
module loader_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic clear,
  input  logic increment,
  output logic terminal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (increment) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign terminal = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/register.sv
// Multi-mode WIDTH-bit register: clear, parallel load, serial loads and
// logical shifts selected by a 3-bit ctrl code.
module register
  import register_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic [2:0]       ctrl,
  input  logic             serial_data_input,
  input  logic [WIDTH-1:0] parallel_data_input,
  output logic [WIDTH-1:0] data_output
);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      data_output <= '0;
    end else begin
      case (ctrl)
        CTRL_CLR:                 data_output <= '0;
        CTRL_PARALLEL_LOAD:       data_output <= parallel_data_input;
        CTRL_SERIAL_MSB_LOAD:     data_output <= {serial_data_input, data_output[WIDTH-1:1]};
        CTRL_SERIAL_LSB_LOAD:     data_output <= {data_output[WIDTH-2:0], serial_data_input};
        CTRL_SHIFT_LOGICAL_LEFT:  data_output <= {data_output[WIDTH-2:0], 1'b0};
        CTRL_SHIFT_LOGICAL_RIGHT: data_output <= {1'b0, data_output[WIDTH-1:1]};
        default:                  data_output <= data_output;
      endcase
    end
  end

endmodule

// File: rtl/register_serial_loader.sv
// Serial-bit to word loader driving an external register's ctrl/serial input.
// Define REGISTER_SERIAL_LOADER_PARITY_EN to add an even-parity bit and parity_error.
module register_serial_loader
  import register_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic [2:0]       reg_ctrl,
  output logic             reg_serial_data_input,
  input  logic [WIDTH-1:0] reg_data_output,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_data,
  input  logic             word_ready,
`ifdef REGISTER_SERIAL_LOADER_PARITY_EN
  output logic             parity_error,
`endif
  output logic             busy
);

  localparam logic [2:0] LOAD_CODE = MSB_FIRST ? CTRL_SERIAL_LSB_LOAD : CTRL_SERIAL_MSB_LOAD;

  loader_state_t state_reg, state_next;
  logic          cnt_clear, cnt_inc, cnt_terminal;

  loader_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk          (clk),
    .async_nreset (async_nreset),
    .clear        (cnt_clear),
    .increment    (cnt_inc),
    .terminal     (cnt_terminal)
  );

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) state_reg <= S_IDLE;
    else               state_reg <= state_next;
  end

  always_comb begin
    state_next            = state_reg;
    reg_ctrl              = CTRL_NONE;
    reg_serial_data_input = 1'b0;
    bit_ready             = 1'b0;
    word_valid            = 1'b0;
    cnt_clear             = 1'b0;
    cnt_inc               = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        reg_ctrl   = CTRL_CLR;
        cnt_clear  = 1'b1;
        state_next = S_RECEIVE;
      end
      S_RECEIVE: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          reg_ctrl              = LOAD_CODE;
          reg_serial_data_input = bit_in;
          cnt_inc               = 1'b1;
          if (cnt_terminal) begin
            // Clearing on the last bit keeps the count within 0..WIDTH-1.
            cnt_clear = 1'b1;
`ifdef REGISTER_SERIAL_LOADER_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_DONE;
`endif
          end
        end
      end
`ifdef REGISTER_SERIAL_LOADER_PARITY_EN
      S_PARITY: begin
        bit_ready = 1'b1;
        if (bit_valid) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        word_valid = 1'b1;
        if (word_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Abort overrides any handshake so neither side sees a transfer.
    if (abort) begin
      state_next            = S_IDLE;
      reg_ctrl              = CTRL_CLR;
      reg_serial_data_input = 1'b0;
      bit_ready             = 1'b0;
      word_valid            = 1'b0;
      cnt_clear             = 1'b1;
      cnt_inc               = 1'b0;
    end
    if (!async_nreset) reg_ctrl = CTRL_NONE;
  end

`ifdef REGISTER_SERIAL_LOADER_PARITY_EN
  logic parity_acc_reg;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      parity_acc_reg <= 1'b0;
    end else if (abort || state_reg == S_CLEAR) begin
      parity_acc_reg <= 1'b0;
    end else if ((state_reg == S_RECEIVE || state_reg == S_PARITY) && bit_valid) begin
      parity_acc_reg <= parity_acc_reg ^ bit_in;
    end
  end

  assign parity_error = word_valid & parity_acc_reg;
`endif

  assign word_data = reg_data_output;
  assign busy      = (state_reg != S_IDLE);

endmodule
